vga_timing_controller: RTL and testbench

//  Sequences the horizontal and vertical position counters of the VGA path through

---
 rtl/vga_timing_pkg.sv | 44 ++++
 rtl/vga_axis_sequencer.sv | 73 +++++++
 rtl/vga_timing_controller.sv | 113 +++++++++++
 tb/tb_vga_timing_controller.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared phase encoding, default 640x480@60 timing and width helpers for the
// VGA timing path.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phase_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic phase_t next_phase(phase_t p);
    case (p)
      PH_ACTIVE: return PH_FP;
      PH_FP:     return PH_SYNC;
      PH_SYNC:   return PH_BP;
      default:   return PH_ACTIVE;
    endcase
  endfunction

  // Width able to hold 0..max_len-1 for the longest phase; never below 1 bit.
  function automatic int count_width(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic int coord_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_axis_sequencer.sv
// One timing axis: phase FSM ACTIVE->FP->SYNC->BP->ACTIVE with an in-phase
// counter; last flags the final count of the back porch (end of axis period).
module vga_axis_sequencer
  import vga_timing_pkg::*;
#(
  parameter int  ACTIVE = DEF_H_ACTIVE,
  parameter int  FP     = DEF_H_FP,
  parameter int  SYNC   = DEF_H_SYNC,
  parameter int  BP     = DEF_H_BP,
  localparam int CW     = count_width(ACTIVE, FP, SYNC, BP)
) (
  input  logic          clk,
  input  logic          async_reset_n,
  input  logic          clr,
  input  logic          step,
  output phase_t        phase,
  output logic [CW-1:0] count,
  output logic          last
);

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_len
    $error("vga_axis_sequencer: every phase length must be >= 1");
  end

  phase_t        phase_q, phase_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] len_m1;
  logic          at_end;

  always_comb begin
    len_m1 = CW'(ACTIVE - 1);
    case (phase_q)
      PH_FP:   len_m1 = CW'(FP - 1);
      PH_SYNC: len_m1 = CW'(SYNC - 1);
      PH_BP:   len_m1 = CW'(BP - 1);
      default: len_m1 = CW'(ACTIVE - 1);
    endcase
  end

  assign at_end = (count_q == len_m1);

  // Clear wins over step so a stopped controller always parks at the origin.
  always_comb begin
    phase_d = phase_q;
    count_d = count_q;
    if (clr) begin
      phase_d = PH_ACTIVE;
      count_d = '0;
    end else if (step) begin
      if (at_end) begin
        phase_d = next_phase(phase_q);
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      phase_q <= PH_ACTIVE;
      count_q <= '0;
    end else begin
      phase_q <= phase_d;
      count_q <= count_d;
    end
  end

  assign phase = phase_q;
  assign count = count_q;
  assign last  = (phase_q == PH_BP) && at_end;

endmodule

// File: rtl/vga_timing_controller.sv
// VGA timing generator: horizontal and vertical axis sequencers stepped by the
// pixel-clock enable, with sync, display-enable, coordinate and pulse decode.
module vga_timing_controller
  import vga_timing_pkg::*;
#(
  parameter int  H_ACTIVE  = DEF_H_ACTIVE,
  parameter int  H_FP      = DEF_H_FP,
  parameter int  H_SYNC    = DEF_H_SYNC,
  parameter int  H_BP      = DEF_H_BP,
  parameter int  V_ACTIVE  = DEF_V_ACTIVE,
  parameter int  V_FP      = DEF_V_FP,
  parameter int  V_SYNC    = DEF_V_SYNC,
  parameter int  V_BP      = DEF_V_BP,
  parameter bit  HSYNC_POL = 1'b0,
  parameter bit  VSYNC_POL = 1'b0,
  localparam int XW        = coord_width(H_ACTIVE),
  localparam int YW        = coord_width(V_ACTIVE),
  localparam int HCW       = count_width(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int VCW       = count_width(V_ACTIVE, V_FP, V_SYNC, V_BP)
) (
  input  logic          clk,
  input  logic          async_reset_n,
  input  logic          run,
  input  logic          pix_tick,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic          display_en,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
);

  logic run_q, run_d;

  assign run_d = run;

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= run_d;
    end
  end

  phase_t         h_phase, v_phase;
  logic [HCW-1:0] h_count;
  logic [VCW-1:0] v_count;
  logic           h_last, v_last;
  logic           axis_clr, h_step, v_step;

  // The vertical axis advances once per line, on the step that ends the back porch.
  assign axis_clr = ~run_q;
  assign h_step   = run_q & pix_tick;
  assign v_step   = h_step & h_last;

  vga_axis_sequencer #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .clr           (axis_clr),
    .step          (h_step),
    .phase         (h_phase),
    .count         (h_count),
    .last          (h_last)
  );

  vga_axis_sequencer #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .clr           (axis_clr),
    .step          (v_step),
    .phase         (v_phase),
    .count         (v_count),
    .last          (v_last)
  );

  logic h_act, v_act, h_origin, v_origin;

  assign h_act    = run_q && (h_phase == PH_ACTIVE);
  assign v_act    = run_q && (v_phase == PH_ACTIVE);
  assign h_origin = (h_phase == PH_ACTIVE) && (h_count == '0);
  assign v_origin = (v_phase == PH_ACTIVE) && (v_count == '0);

  // Everything is gated by run_q so the cycle after run drops is already
  // blanked, before the axes have been cleared back to the origin.
  always_comb begin
    pixel_x     = '0;
    pixel_y     = '0;
    display_en  = h_act && v_act;
    hsync       = ~HSYNC_POL;
    vsync       = ~VSYNC_POL;
    line_start  = h_step && h_origin;
    frame_start = h_step && h_origin && v_origin;
    if (h_act) pixel_x = h_count[XW-1:0];
    if (v_act) pixel_y = v_count[YW-1:0];
    if (run_q && (h_phase == PH_SYNC)) hsync = HSYNC_POL;
    if (run_q && (v_phase == PH_SYNC)) vsync = VSYNC_POL;
  end

  logic unused_v_last;
  assign unused_v_last = v_last;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller: four instances (default and small timing,
// each with both sync polarities) compared every cycle against a position model.
module tb_vga_timing_controller;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hpol, vpol;
  } cfg_t;

  typedef struct {
    int x, y;
    bit de, hs, vs, ls, fs;
  } exp_t;

  cfg_t CFG_A = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  cfg_t CFG_C = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b1};
  cfg_t CFG_B = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0};
  cfg_t CFG_D = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1};

  logic clk = 1'b0;
  logic rst_n;
  logic run1, tick1, run2, tick2;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  logic [9:0] a_x, c_x;
  logic [8:0] a_y, c_y;
  logic [1:0] b_x, b_y, d_x, d_y;
  logic a_de, a_hs, a_vs, a_ls, a_fs;
  logic b_de, b_hs, b_vs, b_ls, b_fs;
  logic c_de, c_hs, c_vs, c_ls, c_fs;
  logic d_de, d_hs, d_vs, d_ls, d_fs;

  vga_timing_controller u_a (
    .clk(clk), .async_reset_n(rst_n), .run(run1), .pix_tick(tick1),
    .pixel_x(a_x), .pixel_y(a_y), .display_en(a_de), .hsync(a_hs), .vsync(a_vs),
    .line_start(a_ls), .frame_start(a_fs));

  vga_timing_controller #(.HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) u_c (
    .clk(clk), .async_reset_n(rst_n), .run(run1), .pix_tick(tick1),
    .pixel_x(c_x), .pixel_y(c_y), .display_en(c_de), .hsync(c_hs), .vsync(c_vs),
    .line_start(c_ls), .frame_start(c_fs));

  vga_timing_controller #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                          .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_b (
    .clk(clk), .async_reset_n(rst_n), .run(run2), .pix_tick(tick2),
    .pixel_x(b_x), .pixel_y(b_y), .display_en(b_de), .hsync(b_hs), .vsync(b_vs),
    .line_start(b_ls), .frame_start(b_fs));

  vga_timing_controller #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                          .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                          .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) u_d (
    .clk(clk), .async_reset_n(rst_n), .run(run2), .pix_tick(tick2),
    .pixel_x(d_x), .pixel_y(d_y), .display_en(d_de), .hsync(d_hs), .vsync(d_vs),
    .line_start(d_ls), .frame_start(d_fs));

  // Model: a frame is one linear sequence of steps; s is the step index.
  function automatic int frame_len(cfg_t c);
    return (c.ha + c.hf + c.hs + c.hb) * (c.va + c.vf + c.vs + c.vb);
  endfunction

  function automatic exp_t model(cfg_t c, bit rq, int s, bit tick);
    exp_t e;
    int ht, hp, vp;
    bit hact, vact, hsy, vsy;
    ht   = c.ha + c.hf + c.hs + c.hb;
    hp   = s % ht;
    vp   = s / ht;
    hact = hp < c.ha;
    vact = vp < c.va;
    hsy  = (hp >= c.ha + c.hf) && (hp < c.ha + c.hf + c.hs);
    vsy  = (vp >= c.va + c.vf) && (vp < c.va + c.vf + c.vs);
    e.x  = (rq && hact) ? hp : 0;
    e.y  = (rq && vact) ? vp : 0;
    e.de = rq && hact && vact;
    e.hs = (rq && hsy) ? c.hpol : !c.hpol;
    e.vs = (rq && vsy) ? c.vpol : !c.vpol;
    e.ls = rq && tick && (hp == 0);
    e.fs = rq && tick && (s == 0);
    return e;
  endfunction

  bit rq1 = 1'b0, rq2 = 1'b0;
  int s1 = 0, s2 = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq1 <= 1'b0; s1 <= 0;
      rq2 <= 1'b0; s2 <= 0;
    end else begin
      rq1 <= run1;
      rq2 <= run2;
      s1  <= !rq1 ? 0 : (tick1 ? (s1 + 1) % frame_len(CFG_A) : s1);
      s2  <= !rq2 ? 0 : (tick2 ? (s2 + 1) % frame_len(CFG_B) : s2);
    end
  end

  task automatic cmp(string nm, cfg_t c, bit rq, int s, bit tick,
                     int ax, int ay, bit ade, bit ahs, bit avs, bit als, bit afs);
    exp_t e;
    e = model(c, rq, s, tick);
    checks++;
    if (ax != e.x || ay != e.y || ade != e.de || ahs != e.hs || avs != e.vs ||
        als != e.ls || afs != e.fs) begin
      fails++;
      $display("FAIL %s s=%0d got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b want x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
               nm, s, ax, ay, ade, ahs, avs, als, afs, e.x, e.y, e.de, e.hs, e.vs, e.ls, e.fs);
    end
  endtask

  task automatic chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", nm, act, req);
    end
  endtask

  int cyc = 0;
  int nls_a = 0, t_hs_a = 0, hs_cnt_a = 0, de_cnt_a = 0;
  int t_ls_a[2];
  int nfs_b = 0, nls_b = 0, vs_cnt_b = 0, de_cnt_b = 0;
  int t_fs_b[2], t_ls_b[2];

  always @(negedge clk) begin
    cyc++;
    cmp("dut_a", CFG_A, rq1, s1, tick1, int'(a_x), int'(a_y), a_de, a_hs, a_vs, a_ls, a_fs);
    cmp("dut_c", CFG_C, rq1, s1, tick1, int'(c_x), int'(c_y), c_de, c_hs, c_vs, c_ls, c_fs);
    cmp("dut_b", CFG_B, rq2, s2, tick2, int'(b_x), int'(b_y), b_de, b_hs, b_vs, b_ls, b_fs);
    cmp("dut_d", CFG_D, rq2, s2, tick2, int'(d_x), int'(d_y), d_de, d_hs, d_vs, d_ls, d_fs);
    if (a_ls) begin
      if (nls_a < 2) t_ls_a[nls_a] = cyc;
      nls_a++;
    end
    if (nls_a == 1) begin
      if (!a_hs) begin
        if (hs_cnt_a == 0) t_hs_a = cyc;
        hs_cnt_a++;
      end
      if (a_de) de_cnt_a++;
    end
    if (b_fs) begin
      if (nfs_b < 2) t_fs_b[nfs_b] = cyc;
      nfs_b++;
    end
    if (nfs_b == 1) begin
      if (b_ls && nls_b < 2) begin
        t_ls_b[nls_b] = cyc;
        nls_b++;
      end
      if (!b_vs) vs_cnt_b++;
      if (b_de) de_cnt_b++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Small-config stimulus: tick every second cycle first, then random.
  initial begin
    int n2;
    n2 = 0;
    run2 = 1'b1;
    tick2 = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      n2++;
      if (n2 < 1500) begin
        tick2 = ~tick2;
      end else begin
        tick2 = 1'($urandom_range(0, 1));
        run2  = ($urandom_range(0, 99) != 0);
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    run1  = 1'b0;
    tick1 = 1'b1;
    repeat (3) step();
    chk("rst_x", int'(a_x), 0);
    chk("rst_de", int'(a_de), 0);
    chk("rst_hsync", int'(a_hs), 1);
    chk("rst_vsync_inv", int'(c_vs), 0);
    chk("rst_fs", int'(a_fs), 0);
    rst_n = 1'b1;
    step();
    run1 = 1'b1;
    repeat (2000) step();

    chk("line_period", t_ls_a[1] - t_ls_a[0], 800);
    chk("hsync_start", t_hs_a - t_ls_a[0], 656);
    chk("hsync_width", hs_cnt_a, 96);
    chk("de_per_line", de_cnt_a, 640);
    chk("small_frame", t_fs_b[1] - t_fs_b[0], 96);
    chk("small_line", t_ls_b[1] - t_ls_b[0], 16);
    chk("small_vsync", vs_cnt_b, 16);
    chk("small_de", de_cnt_b, 24);

    n = 0;
    while (!(a_x == 10'd100 && a_y == 9'd20) && n < 20000) begin
      step();
      n++;
    end
    chk("reach_100_20", int'(n < 20000), 1);
    run1 = 1'b0;
    step();
    chk("drop_de", int'(a_de), 0);
    chk("drop_x", int'(a_x), 0);
    chk("drop_y", int'(a_y), 0);
    chk("drop_hsync", int'(a_hs), 1);
    chk("drop_hsync_inv", int'(c_hs), 0);
    repeat (3) step();
    run1 = 1'b1;
    step();
    chk("resume_fs", int'(a_fs), 1);
    chk("resume_x", int'(a_x), 0);
    chk("resume_de", int'(a_de), 1);

    n = 0;
    while (a_hs && n < 1000) begin
      step();
      n++;
    end
    chk("reach_hsync", int'(a_hs), 0);
    chk("hsync_inv", int'(c_hs), 1);
    rst_n = 1'b0;
    #1;
    chk("async_hsync", int'(a_hs), 1);
    chk("async_hsync_inv", int'(c_hs), 0);
    chk("async_x", int'(a_x), 0);
    chk("async_de", int'(a_de), 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("restart_fs", int'(a_fs), 1);
    chk("restart_x", int'(a_x), 0);

    repeat (4000) begin
      tick1 = ($urandom_range(0, 3) != 0);
      run1  = ($urandom_range(0, 299) != 0);
      step();
    end
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
